// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load type codes, register-write enable code and
// the load unit state encoding.
package cpu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [1:0] REGWRITE_EN = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2,
        ERR  = 2'd3
    } load_state_t;

endpackage

// File: rtl/load_extract.sv
// Combinational lane select, sign/zero extension, byte-enable generation
// and legality check for a single load.
module load_extract
    import cpu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  load_type_i,
    output logic [31:0] result_o,
    output logic [3:0]  byteenable_o,
    output logic        legal_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word_i[{off_i, 3'b000} +: 8];
    assign half_sel = word_i[{off_i[1], 4'b0000} +: 16];

    always_comb begin
        result_o     = '0;
        byteenable_o = '0;
        legal_o      = 1'b0;
        case (load_type_i)
            LB: begin
                legal_o      = 1'b1;
                byteenable_o = 4'b0001 << off_i;
                result_o     = {{24{byte_sel[7]}}, byte_sel};
            end
            LBU: begin
                legal_o      = 1'b1;
                byteenable_o = 4'b0001 << off_i;
                result_o     = {24'h0, byte_sel};
            end
            LH: begin
                legal_o      = ~off_i[0];
                byteenable_o = 4'b0011 << off_i;
                result_o     = {{16{half_sel[15]}}, half_sel};
            end
            LHU: begin
                legal_o      = ~off_i[0];
                byteenable_o = 4'b0011 << off_i;
                result_o     = {16'h0, half_sel};
            end
            LW: begin
                legal_o      = (off_i == 2'b00);
                byteenable_o = 4'b1111;
                result_o     = word_i;
            end
            default: begin
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/load_read_unit.sv
// Load unit: one Avalon-style read per request, result delivered as a
// single-cycle register write. All outputs are registered.
module load_read_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        load_type,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic [3:0]        byteenable,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata,
    output logic              busy,
    output logic [1:0]        RegWrite,
    output logic [DATA_W-1:0] WriteData,
    output logic              load_err,
    output load_state_t       state_dbg
);

    if (DATA_W != 32) begin : g_width_check
        $error("load_read_unit: DATA_W must be 32");
    end

    load_state_t       state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [3:0]        be_q, be_d;
    logic              read_q, read_d;
    logic              busy_q, busy_d;
    logic [1:0]        rw_q, rw_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [2:0]        type_q, type_d;
    logic [1:0]        off_q, off_d;

    logic [1:0]        sel_off;
    logic [2:0]        sel_type;
    logic [31:0]       ext_result;
    logic [3:0]        ext_be;
    logic              ext_legal;

    // In IDLE the extractor checks the incoming request; afterwards it
    // works on the latched request and the live bus data.
    assign sel_off  = (state_q == IDLE) ? load_addr[1:0] : off_q;
    assign sel_type = (state_q == IDLE) ? load_type      : type_q;

    load_extract u_extract (
        .word_i       (readdata),
        .off_i        (sel_off),
        .load_type_i  (sel_type),
        .result_o     (ext_result),
        .byteenable_o (ext_be),
        .legal_o      (ext_legal)
    );

    // Bus handshake: a read transfer completes in the cycle where read=1 and
    // waitrequest=0; until then address, byteenable and read stay constant.
    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        type_d    = type_q;
        off_d     = off_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ext_legal) begin
                        state_d   = REQ;
                        address_d = {load_addr[ADDR_W-1:2], 2'b00};
                        be_d      = ext_be;
                        type_d    = load_type;
                        off_d     = load_addr[1:0];
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            REQ: begin
                if (!waitrequest) begin
                    state_d = WB;
                    wdata_d = ext_result;
                end
            end
            WB:      state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        read_d = (state_d == REQ);
        busy_d = (state_d != IDLE);
        rw_d   = (state_d == WB) ? REGWRITE_EN : 2'b00;
        err_d  = (state_d == ERR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            address_q <= '0;
            be_q      <= '0;
            read_q    <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= 2'b00;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            type_q    <= '0;
            off_q     <= '0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            be_q      <= be_d;
            read_q    <= read_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            type_q    <= type_d;
            off_q     <= off_d;
        end
    end

    assign address    = address_q;
    assign read       = read_q;
    assign byteenable = be_q;
    assign busy       = busy_q;
    assign RegWrite   = rw_q;
    assign WriteData  = wdata_q;
    assign load_err   = err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_load_read_unit.sv
// Bench for load_read_unit: directed and random loads against an arithmetic
// reference model, results checked by a queue-based scoreboard monitor.
module tb_load_read_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  load_type;
    logic [31:0] load_addr;
    logic [31:0] address;
    logic        read;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        busy;
    logic [1:0]  RegWrite;
    logic [31:0] WriteData;
    logic        load_err;
    load_state_t state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_xfer = 0;
    int act_xfer = 0;

    // bit 32 = error expected, bits 31:0 = expected WriteData
    logic [32:0] exp_q[$];

    load_read_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .load_type   (load_type),
        .load_addr   (load_addr),
        .address     (address),
        .read        (read),
        .byteenable  (byteenable),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .busy        (busy),
        .RegWrite    (RegWrite),
        .WriteData   (WriteData),
        .load_err    (load_err),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model written from the load rules with plain arithmetic.
    task automatic model(input logic [2:0] lt, input logic [31:0] addr, input logic [31:0] word,
                         output bit legal, output logic [3:0] be, output logic [31:0] res);
        int unsigned off;
        logic [31:0] byte_v;
        logic [31:0] half_v;
        off    = int'(addr % 4);
        byte_v = (word >> (8 * off)) & 32'hFF;
        half_v = (word >> (16 * (off / 2))) & 32'hFFFF;
        legal  = 1'b0;
        be     = 4'h0;
        res    = 32'h0;
        case (lt)
            3'b000: begin legal = 1'b1; be = 4'(1 << off); res = (byte_v >= 128) ? byte_v - 32'd256 : byte_v; end
            3'b100: begin legal = 1'b1; be = 4'(1 << off); res = byte_v; end
            3'b001: begin legal = (off % 2 == 0); be = 4'(3 << off); res = (half_v >= 32768) ? half_v - 32'd65536 : half_v; end
            3'b101: begin legal = (off % 2 == 0); be = 4'(3 << off); res = half_v; end
            3'b010: begin legal = (off == 0); be = 4'hF; res = word; end
            default: legal = 1'b0;
        endcase
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && (RegWrite != 2'b00 || load_err)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: RegWrite=%b load_err=%b with nothing expected at %0t",
                         RegWrite, load_err, $time);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("sb_kind", 32'({RegWrite, load_err}), e[32] ? 32'd1 : 32'd6);
                if (!e[32]) check("sb_write_data", WriteData, e[31:0]);
            end
        end
    end

    // Count completed bus transfers.
    always @(posedge clk) begin
        if (!reset && read && !waitrequest) act_xfer++;
    end

    // ---------------- driver tasks ----------------
    task automatic do_load(input logic [2:0] lt, input logic [31:0] addr, input logic [31:0] word,
                           input int nwait, input bit pulse);
        bit          legal;
        logic [3:0]  be;
        logic [31:0] res;
        model(lt, addr, word, legal, be, res);
        exp_q.push_back(legal ? {1'b0, res} : {1'b1, 32'h0});
        start       = 1'b1;
        load_type   = lt;
        load_addr   = addr;
        waitrequest = 1'($urandom_range(0, 1));
        readdata    = $urandom();
        @(negedge clk);
        start     = 1'b0;
        load_type = 3'($urandom_range(0, 7));
        load_addr = $urandom();
        if (legal) begin
            exp_xfer++;
            for (int k = 0; k <= nwait; k++) begin
                check("req_read", 32'(read), 32'd1);
                check("req_addr", address, {addr[31:2], 2'b00});
                check("req_be", 32'(byteenable), 32'(be));
                check("req_busy", 32'(busy), 32'd1);
                check("req_rw", 32'(RegWrite), 32'd0);
                waitrequest = (k < nwait);
                readdata    = (k == nwait) ? word : $urandom();
                start       = pulse && (k == 0);
                if (start) begin
                    load_type = LW;
                    load_addr = $urandom() & 32'hFFFF_FFFC;
                end
                @(negedge clk);
            end
            check("wb_read", 32'(read), 32'd0);
            check("wb_rw", 32'(RegWrite), 32'd3);
            check("wb_busy", 32'(busy), 32'd1);
            start       = pulse;
            waitrequest = 1'($urandom_range(0, 1));
            readdata    = $urandom();
            @(negedge clk);
            start = 1'b0;
        end else begin
            check("err_read", 32'(read), 32'd0);
            check("err_pulse", 32'(load_err), 32'd1);
            check("err_rw", 32'(RegWrite), 32'd0);
            check("err_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_read", 32'(read), 32'd0);
        check("idle_rw", 32'(RegWrite), 32'd0);
        check("idle_err", 32'(load_err), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic abort_load(input logic [31:0] addr);
        start       = 1'b1;
        load_type   = LW;
        load_addr   = addr;
        waitrequest = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_req_read", 32'(read), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_read", 32'(read), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rw", 32'(RegWrite), 32'd0);
        check("abort_addr", address, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset       = 1'b0;
        waitrequest = 1'b0;
        @(negedge clk);
        check("abort_no_rw", 32'(RegWrite), 32'd0);
    endtask

    // ---------------- reset + stimulus ----------------
    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        load_type   = 3'b000;
        load_addr   = 32'h0;
        waitrequest = 1'b0;
        readdata    = 32'h0;
        #3;
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check("rst_read", 32'(read), 32'd0);
        check("rst_addr", address, 32'd0);
        check("rst_be", 32'(byteenable), 32'd0);
        check("rst_rw", 32'(RegWrite), 32'd0);
        check("rst_wdata", WriteData, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        do_load(LW,  32'h0000_1000, 32'hDEAD_BEEF, 0, 1'b0);
        do_load(LB,  32'h0000_1003, 32'h8011_2233, 3, 1'b0);
        do_load(LBU, 32'h0000_1003, 32'h8011_2233, 0, 1'b0);
        do_load(LH,  32'h0000_1002, 32'h8001_7FFF, 1, 1'b0);
        do_load(LHU, 32'h0000_1002, 32'h8001_7FFF, 0, 1'b0);
        do_load(LH,  32'h0000_1000, 32'h8001_7FFF, 0, 1'b0);
        check("hold_wdata", WriteData, 32'h0000_7FFF);
        do_load(LW,  32'h0000_1001, 32'h1234_5678, 0, 1'b0);
        do_load(3'b111, 32'h0000_1000, 32'h1234_5678, 0, 1'b0);
        do_load(LHU, 32'h0000_2003, 32'h1234_5678, 0, 1'b0);
        do_load(LW,  32'h0000_3000, 32'hCAFE_F00D, 2, 1'b1);

        abort_load(32'h0000_4000);
        do_load(LW, 32'h0000_5000, 32'h0BAD_CAFE, 0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            logic [2:0]  lt;
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0, 1:    lt = LB;
                2:       lt = LBU;
                3, 4:    lt = LH;
                5:       lt = LHU;
                6, 7:    lt = LW;
                default: lt = 3'($urandom_range(0, 7));
            endcase
            a = $urandom();
            if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
            do_load(lt, a, $urandom(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("bus_transfer_count", 32'(act_xfer), 32'(exp_xfer));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
